// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
//   Bundles the raw pushbutton inputs and the conditioned outputs of the
//   stopwatch button front end.
//
//   Signals (all 1 bit):
//     start_stop_raw, hold_raw : raw active-low pushbuttons (driven by master)
//     start_stop, hold         : debounced active-low levels
//     start_stop_press         : one-cycle pulse on a debounced press
//     hold_press               : one-cycle pulse on a debounced press
//     run                      : toggles on each start/stop press
//     clear_req                : one-cycle long-press pulse
//
//   Modports:
//     master : drives the raw buttons, observes the conditioned outputs
//     slave  : the conditioner itself
// ---------------------------------------------------------------------------
interface button_conditioner_if;
  logic start_stop_raw;
  logic hold_raw;
  logic start_stop;
  logic hold;
  logic start_stop_press;
  logic hold_press;
  logic run;
  logic clear_req;

  modport master (
    output start_stop_raw, hold_raw,
    input  start_stop, hold, start_stop_press, hold_press, run, clear_req
  );

  modport slave (
    input  start_stop_raw, hold_raw,
    output start_stop, hold, start_stop_press, hold_press, run, clear_req
  );
endinterface

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Front end for the stopwatch buttons. Each raw active-low button is
//   synchronised (2 flops), debounced (counter + registered stable level) and
//   turned into a clean level plus a one-cycle press pulse. A start/stop press
//   toggles the run level. With BUTTON_LONG_PRESS_EN defined, holding
//   start/stop for LONG_PRESS_CYCLES after its press raises a single
//   clear_req pulse and forces run low; otherwise clear_req is tied 0.
//
//   Parameters:
//     DEBOUNCE_CYCLES   : cycles a synchronised input must stay constant (>= 2)
//     LONG_PRESS_CYCLES : long-press duration, must exceed DEBOUNCE_CYCLES
//
//   Ports:
//     CLK_50MHz : clock
//     reset_n   : asynchronous active-low reset
//     btn       : button_conditioner_if.slave (raw inputs, conditioned outputs)
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic                CLK_50MHz,
  input  logic                reset_n,
  button_conditioner_if.slave btn
);

  localparam int              DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations the debounce/long-press timing cannot honour.
  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
    $error("button_conditioner: illegal DEBOUNCE_CYCLES / LONG_PRESS_CYCLES");
  end

  // Channel 0 = start/stop, channel 1 = hold.
  logic [1:0] raw_w;
  logic [1:0] level_w;
  logic [1:0] press_w;
  logic       ss_fall;

  assign raw_w = {btn.hold_raw, btn.start_stop_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;
      logic            press_reg;
      logic [DB_W-1:0] cnt_reg;
      logic            accept;
      logic            fall;

      // The synchronised value has differed for DEBOUNCE_CYCLES evaluations
      // in a row; >= keeps the counter saturating rather than wrapping.
      assign accept = (sync2_reg != level_reg) && (cnt_reg >= DB_MAX);
      // Press = accepted change while the stable level is still released.
      assign fall   = accept && level_reg;

      always_ff @(posedge CLK_50MHz or negedge reset_n) begin
        if (!reset_n) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          level_reg <= 1'b1;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw_w[gi];
          sync2_reg <= sync1_reg;
          press_reg <= fall;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (accept) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign level_w[gi] = level_reg;
      assign press_w[gi] = press_reg;
    end
  endgenerate

  // The long-press timer starts on the same edge the press pulse is
  // registered, so clear_req lands exactly LONG_PRESS_CYCLES edges later.
  assign ss_fall = g_ch[0].fall;

  logic run_reg;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int              LP_W   = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_PRESS_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TIMING = 2'd1;
  localparam logic [1:0] ST_FIRED  = 2'd2;

  logic [1:0]      state_reg;
  logic [LP_W-1:0] lp_cnt_reg;
  logic            clear_reg;

  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      lp_cnt_reg <= '0;
      clear_reg  <= 1'b0;
      run_reg    <= 1'b0;
    end else begin
      clear_reg <= 1'b0;
      if (ss_fall) begin
        run_reg <= ~run_reg;
      end
      case (state_reg)
        ST_IDLE: begin
          if (ss_fall) begin
            state_reg  <= ST_TIMING;
            lp_cnt_reg <= '0;
          end
        end
        ST_TIMING: begin
          if (level_w[0]) begin
            state_reg <= ST_IDLE;
          end else if (lp_cnt_reg >= LP_MAX) begin
            // Fire once; FIRED waits for release so a held button cannot
            // retrigger. Forcing run low takes priority over any toggle.
            state_reg <= ST_FIRED;
            clear_reg <= 1'b1;
            run_reg   <= 1'b0;
          end else begin
            lp_cnt_reg <= lp_cnt_reg + 1'b1;
          end
        end
        ST_FIRED: begin
          if (level_w[0]) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign btn.clear_req = clear_reg;
`else
  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      run_reg <= 1'b0;
    end else if (ss_fall) begin
      run_reg <= ~run_reg;
    end
  end

  assign btn.clear_req = 1'b0;
`endif

  assign btn.start_stop       = level_w[0];
  assign btn.hold             = level_w[1];
  assign btn.start_stop_press = press_w[0];
  assign btn.hold_press       = press_w[1];
  assign btn.run              = run_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//   Self-checking bench: a per-edge vector table, hand-written corner-case
//   sequences and randomized chatter/hold patterns, all checked each edge
//   against a window-based reference model.
// ---------------------------------------------------------------------------
module tb_button_conditioner;
  localparam int DEB  = 4;
  localparam int LONG = 20;
`ifdef BUTTON_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  button_conditioner_if ifc();

  button_conditioner #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .CLK_50MHz(clk),
    .reset_n  (reset_n),
    .btn      (ifc)
  );

  int tests = 0;
  int fails = 0;
  int edge_n;     // index of the next rising edge since reset release
  int last_edge;  // index of the edge just taken

  // Reference model: a level flips when the last DEB synchronised samples
  // (raw samples two edges old) all disagree with it.
  bit q_ss[$];
  bit q_h[$];
  bit m_ss, m_h, m_ssp, m_hp, m_run, m_clr, lp_armed;
  int lp_start;

  typedef struct {
    logic ss_raw, h_raw;
    logic e_ss, e_h, e_ssp, e_hp, e_run;
  } vec_t;
  vec_t vecs[23];

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s edge %0d: got %b expected %b", name, last_edge, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit window_flips(input bit q[$], input bit level);
    for (int i = 0; i < DEB; i++) begin
      if (q[i] == level) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    q_ss.delete();
    q_h.delete();
    for (int i = 0; i <= DEB; i++) begin
      q_ss.push_back(1'b1);
      q_h.push_back(1'b1);
    end
    m_ss = 1'b1; m_h = 1'b1; m_ssp = 1'b0; m_hp = 1'b0;
    m_run = 1'b0; m_clr = 1'b0; lp_armed = 1'b0; lp_start = 0;
    edge_n = 0;
  endtask

  task automatic model_edge(input bit ss_raw, input bit h_raw);
    bit ss_flip;
    bit h_flip;
    ss_flip = window_flips(q_ss, m_ss);
    h_flip  = window_flips(q_h, m_h);
    m_ssp = ss_flip && m_ss;
    m_hp  = h_flip && m_h;
    m_clr = LP_EN && lp_armed && (edge_n == lp_start + LONG);
    if (m_clr) lp_armed = 1'b0;
    if (m_ssp) begin
      lp_armed = LP_EN;
      lp_start = edge_n;
    end
    if (ss_flip && !m_ss) lp_armed = 1'b0;  // release cancels a pending long press
    if (m_clr) m_run = 1'b0;
    else if (m_ssp) m_run = ~m_run;
    if (ss_flip) m_ss = ~m_ss;
    if (h_flip) m_h = ~m_h;
    q_ss.push_back(ss_raw);
    void'(q_ss.pop_front());
    q_h.push_back(h_raw);
    void'(q_h.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(ifc.start_stop_raw, ifc.hold_raw);
    last_edge = edge_n;
    edge_n++;
    #1;
    chk("start_stop", ifc.start_stop, m_ss);
    chk("hold", ifc.hold, m_h);
    chk("start_stop_press", ifc.start_stop_press, m_ssp);
    chk("hold_press", ifc.hold_press, m_hp);
    chk("run", ifc.run, m_run);
    chk("clear_req", ifc.clear_req, m_clr);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_start_stop"}, ifc.start_stop, 1'b1);
    chk({tag, "_hold"}, ifc.hold, 1'b1);
    chk({tag, "_start_stop_press"}, ifc.start_stop_press, 1'b0);
    chk({tag, "_hold_press"}, ifc.hold_press, 1'b0);
    chk({tag, "_run"}, ifc.run, 1'b0);
    chk({tag, "_clear_req"}, ifc.clear_req, 1'b0);
  endtask

  task automatic apply_reset(input int hold_cycles);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset("rst_async");
    repeat (hold_cycles) @(posedge clk);
    @(negedge clk);
    check_reset("rst_held");
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic drive(input logic ss, input logic h, input int n);
    ifc.start_stop_raw = ss;
    ifc.hold_raw       = h;
    repeat (n) step();
  endtask

  initial begin
    int fall;
    int cnt;
    int clr_cnt;
    int clr_edge;
    int press_edge;

    // Per-edge table from reset release: simultaneous press, release,
    // then a lone start/stop press.
    for (int i = 0; i < 5; i++)   vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 6; i < 8; i++)   vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 8; i < 13; i++)  vecs[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 13; i < 16; i++) vecs[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 16; i < 21; i++) vecs[i] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    ifc.start_stop_raw = 1'b1;
    ifc.hold_raw       = 1'b1;
    model_reset();
    apply_reset(2);

    for (int i = 0; i < 23; i++) begin
      ifc.start_stop_raw = vecs[i].ss_raw;
      ifc.hold_raw       = vecs[i].h_raw;
      step();
      chk("vec_start_stop", ifc.start_stop, vecs[i].e_ss);
      chk("vec_hold", ifc.hold, vecs[i].e_h);
      chk("vec_start_stop_press", ifc.start_stop_press, vecs[i].e_ssp);
      chk("vec_hold_press", ifc.hold_press, vecs[i].e_hp);
      chk("vec_run", ifc.run, vecs[i].e_run);
      chk("vec_clear_req", ifc.clear_req, 1'b0);
    end
    drive(1'b1, 1'b1, 10);

    // Reset asserted mid-count with start/stop held low through release.
    drive(1'b0, 1'b1, 3);
    apply_reset(3);
    fall = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fall < 0 && ifc.start_stop == 1'b0) fall = last_edge;
    end
    chk_int("reset_fall_edge", fall, 5);
    chk("reset_run", ifc.run, 1'b1);
    drive(1'b1, 1'b1, 10);

    // Bounce on hold: low 3, high 1, then low.
    apply_reset(1);
    fall = -1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      ifc.hold_raw = (i == 3) ? 1'b1 : 1'b0;
      step();
      if (ifc.hold_press) cnt++;
      if (fall < 0 && ifc.hold == 1'b0) fall = last_edge;
    end
    chk_int("bounce_fall_edge", fall, 9);
    chk_int("bounce_press_count", cnt, 1);
    drive(1'b1, 1'b1, 10);

    // Toggle: two separate presses.
    apply_reset(1);
    drive(1'b0, 1'b1, 8);
    drive(1'b1, 1'b1, 8);
    chk("toggle_run_1", ifc.run, 1'b1);
    drive(1'b0, 1'b1, 8);
    drive(1'b1, 1'b1, 8);
    chk("toggle_run_2", ifc.run, 1'b0);

    // Long press: 40 cycles low.
    apply_reset(1);
    press_edge = -1;
    clr_cnt = 0;
    clr_edge = -1;
    ifc.start_stop_raw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ifc.start_stop_press && press_edge < 0) press_edge = last_edge;
      if (ifc.clear_req) begin
        clr_cnt++;
        if (clr_edge < 0) clr_edge = last_edge;
      end
    end
    chk_int("long_press_edge", press_edge, 5);
    chk_int("long_clear_count", clr_cnt, LP_EN ? 1 : 0);
    chk_int("long_clear_edge", clr_edge, LP_EN ? 25 : -1);
    chk("long_run_end", ifc.run, LP_EN ? 1'b0 : 1'b1);
    drive(1'b1, 1'b1, 10);

    // Randomized chatter and holds, checked by the model every edge.
    for (int seg = 0; seg < 120; seg++) begin
      int mode;
      int len;
      mode = int'($urandom_range(0, 2));
      len  = (mode == 2) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 12));
      if (seg == 60) apply_reset(2);
      for (int c = 0; c < len; c++) begin
        if (mode == 0 || c == 0) begin
          ifc.start_stop_raw = 1'($urandom_range(0, 1));
          ifc.hold_raw       = 1'($urandom_range(0, 1));
        end
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end input stage for the stopwatch: takes the raw active-low `start_stop` and `hold` pushbuttons, synchronises them into the `CLK_50MHz` domain, debounces them, and produces clean active-low levels, one-cycle press pulses and a `run` toggle level. Its outputs drive the stopwatch logic's `start_stop`/`hold` inputs directly. Optionally, a long press of start/stop generates a clear request.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: cycles a synchronised input must stay constant before it is accepted (20 ms at 50 MHz); legal range is 2 or more.
- `LONG_PRESS_CYCLES`, default 100000000: cycles the debounced start/stop must stay pressed to raise `clear_req` (2 s); must be greater than `DEBOUNCE_CYCLES`.

Ports:
- `CLK_50MHz` in 1: the block's one clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `start_stop_raw` in 1: raw pushbutton, active-low, asynchronous to the clock.
- `hold_raw` in 1: raw pushbutton, active-low, asynchronous to the clock.
- `start_stop` out 1: debounced level, active-low.
- `hold` out 1: debounced level, active-low.
- `start_stop_press` out 1: one-cycle pulse on a debounced press (high-to-low).
- `hold_press` out 1: one-cycle pulse on a debounced press.
- `run` out 1: toggles on each `start_stop_press`.
- `clear_req` out 1: one-cycle long-press pulse. Tied 0 when the long-press feature is compiled out.

## Operation
- Per channel: a 2-FF synchroniser (both flops reset to 1), a debounce counter, and a registered stable level.
- Debounce counter rules, evaluated on each clock edge:
  - Synchronised value equals the stable level: counter cleared to 0.
  - Otherwise, counter below `DEBOUNCE_CYCLES-1`: counter increments.
  - Otherwise (counter at `DEBOUNCE_CYCLES-1`): stable level takes the synchronised value and the counter clears.
- Bounce handling: any bounce back to the stable value clears the counter. A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches the outputs.
- Counter widths: `$clog2(DEBOUNCE_CYCLES)` and `$clog2(LONG_PRESS_CYCLES+1)`. Counters saturate and never wrap.
- `*_press`: asserted on the same edge the stable level goes 1 to 0. Deasserted on the next edge. Releases produce no pulse.
- `run`: inverted on every `start_stop_press`.
- Long-press FSM (only when compiled in):
  - IDLE to TIMING on `start_stop_press`; the long counter clears.
  - TIMING: the counter increments each cycle while debounced `start_stop` is 0.
    - Return to IDLE on debounced release.
    - Go to FIRED when the counter reaches `LONG_PRESS_CYCLES-1`. On that edge `clear_req` pulses for one cycle and `run` is forced to 0.
  - FIRED to IDLE on debounced release. Only one `clear_req` per press.
- Simultaneous events:
  - Both channels are independent. Simultaneous presses give both pulses in the same cycle.
  - A `hold_press` in any cycle has no effect on `run` or the FSM.
- Reset values, applied asynchronously whenever `reset_n`=0:
  - `start_stop`=1, `hold`=1.
  - `start_stop_press`=0, `hold_press`=0.
  - `run`=0, `clear_req`=0.
  - All counters 0, FSM in IDLE.
- A button held through reset release is seen as a fresh press once debounced. This is intentional.

## Timing
- Latency: a raw edge sampled at clock edge k appears on the debounced output and press pulse at edge k+1+`DEBOUNCE_CYCLES`. This holds provided the raw level stays constant.
- `clear_req` fires `LONG_PRESS_CYCLES` edges after the edge that raised `start_stop_press`.
- All outputs are registered. No combinational path from raw inputs to outputs.
- Press pulses are exactly one cycle wide. A new press needs at least `DEBOUNCE_CYCLES` released cycles first.
- Reset assertion is asynchronous; deassertion is assumed synchronised upstream to `CLK_50MHz`.

## Configuration
- `BUTTON_LONG_PRESS_EN`: when defined, the long-press FSM and counter are built and `clear_req` behaves as specified.
- When undefined:
  - No long counter or FSM is synthesised.
  - `clear_req` is constant 0.
  - `run` toggles only.
  - `LONG_PRESS_CYCLES` is ignored.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=20.
- Reset check: assert reset mid-count with `start_stop_raw`=0 held.
  - During reset, all outputs are at reset values.
  - After release, `start_stop` falls at edge 5 and `run` goes to 1.
- Clean press: `start_stop_raw` 1→0 sampled at edge 0.
  - `start_stop`=0 and `start_stop_press`=1 at edge 5; press low again at edge 6; `run` 0→1.
- Bounce: `hold_raw` pulses low for 3 cycles, returns high for 1, then stays low.
  - No output during bouncing.
  - `hold` falls 5 edges after the final fall.
  - Exactly one `hold_press`.
- Toggle: two separate debounced presses, each ≥4 cycles with a ≥4-cycle release between them → `run` goes 0→1→0.
- Long press (macro defined): hold `start_stop_raw` low for 40 cycles.
  - `start_stop_press` at edge 5; `run`=1.
  - `clear_req` one-cycle pulse at edge 25, with `run`=0.
  - No second pulse before release.
  - Macro undefined: `clear_req` stays 0 and `run` stays 1.
- Simultaneous: both raw inputs fall at the same edge.
  - Both press pulses appear at edge 5 in the same cycle.
  - `run`=1 and `clear_req` is unaffected by `hold`.
